// File: rtl/controle_fechadura_pkg.sv
// Shared definitions for the lock supervisor: controller state codes and the
// state codes exported by sistema_fechadura.
package controle_fechadura_pkg;

    typedef enum logic [2:0] {
        ST_LIMPA       = 3'd0,
        ST_MONITOR     = 3'd1,
        ST_ESPERA_ERRO = 3'd2,
        ST_BLOQUEIO    = 3'd3,
        ST_ABERTA      = 3'd4
    } estado_ctrl_t;

    // Lock FSM codes: e = (estado == LOCK_E), u = (estado == LOCK_U).
    localparam logic [3:0] LOCK_IDLE = 4'b0000;
    localparam logic [3:0] LOCK_E    = 4'b1111;
    localparam logic [3:0] LOCK_U    = 4'b1000;

endpackage

// File: rtl/controle_fechadura_temporizador.sv
// Down-counter used to time the error, lockout and open windows.
// Load wins over decrement; decrement saturates at zero.
module temporizador_decrescente #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] valor,
    input  logic          dec,
    output logic          zero
);

    logic [TW-1:0] contagem_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            contagem_reg <= '0;
        end else if (load) begin
            contagem_reg <= valor;
        end else if (dec && (contagem_reg != '0)) begin
            contagem_reg <= contagem_reg - 1'b1;
        end
    end

    assign zero = (contagem_reg == '0);

endmodule

// File: rtl/controle_fechadura.sv
// Supervisory controller for sistema_fechadura: gates key presses, clears the
// lock after errors, counts failures, enforces lockout and auto-relocks.
module controle_fechadura
    import controle_fechadura_pkg::*;
#(
    parameter int MAX_TENT        = 3,
    parameter int ERRO_CICLOS     = 4,
    parameter int BLOQUEIO_CICLOS = 16,
    parameter int ABERTA_CICLOS   = 32,
    parameter int TW              = 8,
    localparam int TT             = $clog2(MAX_TENT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tecla_p,
    input  logic          tecla_c,
    input  logic          fechar,
    input  logic          u,
    input  logic          e,
    output logic          p,
    output logic          c,
    output logic          l,
    output logic          bloqueado,
    output logic          aberta,
    output logic          alarme,
    output logic [TT-1:0] tentativas
);

    // Timer holds "cycles remaining minus one", so zero marks the last cycle.
    localparam logic [TW-1:0] ERRO_INI     = TW'(ERRO_CICLOS - 1);
    localparam logic [TW-1:0] BLOQUEIO_INI = TW'(BLOQUEIO_CICLOS - 1);
    localparam logic [TW-1:0] ABERTA_INI   = TW'(ABERTA_CICLOS - 1);
    localparam logic [TT-1:0] MAX_T        = TT'(MAX_TENT);

    estado_ctrl_t  state_reg, state_next;
    logic [TT-1:0] tent_reg, tent_next;
    logic          alarme_reg, alarme_next;

    logic          tmr_load;
    logic [TW-1:0] tmr_valor;
    logic          tmr_dec;
    logic          tmr_zero;

    temporizador_decrescente #(
        .TW(TW)
    ) u_temporizador (
        .clk  (clk),
        .reset(reset),
        .load (tmr_load),
        .valor(tmr_valor),
        .dec  (tmr_dec),
        .zero (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_LIMPA;
            tent_reg   <= '0;
            alarme_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tent_reg   <= tent_next;
            alarme_reg <= alarme_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        tent_next   = tent_reg;
        alarme_next = alarme_reg;
        tmr_load    = 1'b0;
        tmr_valor   = '0;
        tmr_dec     = 1'b0;

        case (state_reg)
            ST_LIMPA: begin
                state_next = ST_MONITOR;
            end

            ST_MONITOR: begin
                // Error is checked first so a simultaneous u never opens the lock.
                if (e) begin
                    tent_next  = (tent_reg == MAX_T) ? tent_reg : tent_reg + 1'b1;
                    tmr_load   = 1'b1;
                    tmr_valor  = ERRO_INI;
                    state_next = ST_ESPERA_ERRO;
                end else if (u) begin
                    tent_next  = '0;
                    tmr_load   = 1'b1;
                    tmr_valor  = ABERTA_INI;
                    state_next = ST_ABERTA;
                end
            end

            ST_ESPERA_ERRO: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    if (tent_reg == MAX_T) begin
                        tmr_load    = 1'b1;
                        tmr_valor   = BLOQUEIO_INI;
                        alarme_next = 1'b1;
                        state_next  = ST_BLOQUEIO;
                    end else begin
                        state_next = ST_LIMPA;
                    end
                end
            end

            ST_BLOQUEIO: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    tent_next   = '0;
                    alarme_next = 1'b0;
                    state_next  = ST_LIMPA;
                end
            end

            ST_ABERTA: begin
                tmr_dec = 1'b1;
                if (fechar || tmr_zero) begin
                    state_next = ST_LIMPA;
                end
            end

            default: begin
                state_next = ST_LIMPA;
            end
        endcase
    end

    assign p          = tecla_p & (state_reg == ST_MONITOR) & ~e & ~u;
    assign c          = tecla_c & p;
    assign l          = (state_reg == ST_LIMPA);
    assign bloqueado  = (state_reg == ST_BLOQUEIO);
    assign aberta     = (state_reg == ST_ABERTA);
    assign alarme     = alarme_reg;
    assign tentativas = tent_reg;

endmodule

// File: tb/tb_controle_fechadura.sv
// Randomized bench for controle_fechadura against a phase/countdown model,
// with a behavioural 4-digit lock (code 1,1,1,1) closing the loop.
module tb_controle_fechadura;

    localparam int MAX_TENT        = 3;
    localparam int ERRO_CICLOS     = 4;
    localparam int BLOQUEIO_CICLOS = 16;
    localparam int ABERTA_CICLOS   = 32;
    localparam int TW              = 8;
    localparam int TT              = $clog2(MAX_TENT + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tecla_p = 1'b0;
    logic          tecla_c = 1'b0;
    logic          fechar = 1'b0;
    logic          u = 1'b0;
    logic          e = 1'b0;
    logic          p, c, l, bloqueado, aberta, alarme;
    logic [TT-1:0] tentativas;

    controle_fechadura #(
        .MAX_TENT       (MAX_TENT),
        .ERRO_CICLOS    (ERRO_CICLOS),
        .BLOQUEIO_CICLOS(BLOQUEIO_CICLOS),
        .ABERTA_CICLOS  (ABERTA_CICLOS),
        .TW             (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tecla_p   (tecla_p),
        .tecla_c   (tecla_c),
        .fechar    (fechar),
        .u         (u),
        .e         (e),
        .p         (p),
        .c         (c),
        .l         (l),
        .bloqueado (bloqueado),
        .aberta    (aberta),
        .alarme    (alarme),
        .tentativas(tentativas)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_erros  = 0;

    // Reference model: current phase plus cycles left in it (including the present one).
    typedef enum {F_LIMPEZA, F_VIGIA, F_ERRO, F_TRAVA, F_ABERTA} fase_t;
    typedef enum {LK_IDLE, LK_ERR, LK_OPEN} lock_t;

    fase_t fase;
    int    restam;
    int    falhas;
    bit    alarme_m;
    lock_t lock_st;
    int    lock_digitos;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s obs=%0h esp=%0h t=%0t", tag, obs, esp, $time);
        end
    endtask

    task automatic modelo_reset();
        fase         = F_LIMPEZA;
        restam       = 0;
        falhas       = 0;
        alarme_m     = 1'b0;
        lock_st      = LK_IDLE;
        lock_digitos = 0;
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model at posedge.
    task automatic ciclo_dir(input bit tp, input bit tc, input bit fc, input bit livre);
        bit exp_p, exp_c, exp_l;
        @(negedge clk);
        tecla_p = tp;
        tecla_c = tc;
        fechar  = fc;
        if (livre) begin
            e = ($urandom_range(0, 5) == 0);
            u = ($urandom_range(0, 5) == 0);
        end else begin
            e = (lock_st == LK_ERR);
            u = (lock_st == LK_OPEN);
        end
        #1;
        exp_p = tp && (fase == F_VIGIA) && !e && !u;
        exp_c = tc && exp_p;
        exp_l = (fase == F_LIMPEZA);
        verifica("p", {31'd0, p}, {31'd0, exp_p});
        verifica("c", {31'd0, c}, {31'd0, exp_c});
        verifica("l", {31'd0, l}, {31'd0, exp_l});
        verifica("bloqueado", {31'd0, bloqueado}, {31'd0, fase == F_TRAVA});
        verifica("aberta", {31'd0, aberta}, {31'd0, fase == F_ABERTA});
        verifica("alarme", {31'd0, alarme}, {31'd0, alarme_m});
        verifica("tentativas", 32'(tentativas), 32'(falhas));
        @(posedge clk);
        // lock reacts to the gated signals seen before the edge
        if (exp_l) begin
            lock_st      = LK_IDLE;
            lock_digitos = 0;
        end else if (exp_p) begin
            if (exp_c) begin
                lock_digitos++;
                if (lock_digitos == 4) lock_st = LK_OPEN;
            end else begin
                lock_st = LK_ERR;
            end
        end
        case (fase)
            F_LIMPEZA: fase = F_VIGIA;
            F_VIGIA: begin
                if (e) begin
                    falhas = (falhas + 1 > MAX_TENT) ? MAX_TENT : falhas + 1;
                    fase   = F_ERRO;
                    restam = ERRO_CICLOS;
                end else if (u) begin
                    falhas = 0;
                    fase   = F_ABERTA;
                    restam = ABERTA_CICLOS;
                end
            end
            F_ERRO: begin
                if (restam == 1) begin
                    if (falhas == MAX_TENT) begin
                        fase     = F_TRAVA;
                        restam   = BLOQUEIO_CICLOS;
                        alarme_m = 1'b1;
                    end else begin
                        fase = F_LIMPEZA;
                    end
                end else restam--;
            end
            F_TRAVA: begin
                if (restam == 1) begin
                    falhas   = 0;
                    alarme_m = 1'b0;
                    fase     = F_LIMPEZA;
                end else restam--;
            end
            F_ABERTA: begin
                if (fc || restam == 1) fase = F_LIMPEZA;
                else restam--;
            end
            default: fase = F_LIMPEZA;
        endcase
    endtask

    task automatic ciclo_aleatorio(input bit livre);
        ciclo_dir($urandom_range(0, 1), ($urandom_range(0, 9) < 8), ($urandom_range(0, 23) == 0), livre);
    endtask

    // Reset asserted just after a negedge, checked immediately and one edge later.
    task automatic aplica_reset();
        @(negedge clk);
        reset   = 1'b0;
        tecla_p = 1'b1;
        tecla_c = 1'b1;
        fechar  = 1'b0;
        e       = 1'b0;
        u       = 1'b0;
        #1;
        modelo_reset();
        verifica("rst_l", {31'd0, l}, 32'd1);
        verifica("rst_p", {31'd0, p}, 32'd0);
        verifica("rst_c", {31'd0, c}, 32'd0);
        verifica("rst_bloqueado", {31'd0, bloqueado}, 32'd0);
        verifica("rst_aberta", {31'd0, aberta}, 32'd0);
        verifica("rst_alarme", {31'd0, alarme}, 32'd0);
        verifica("rst_tentativas", 32'(tentativas), 32'd0);
        @(posedge clk);
        #1;
        verifica("rst_hold_l", {31'd0, l}, 32'd1);
        reset = 1'b1;
    endtask

    initial begin
        int guarda;
        modelo_reset();
        aplica_reset();
        $display("scenario reset_release done");

        for (int i = 0; i < 40; i++) ciclo_aleatorio(1'b0);
        $display("scenario warmup done checks=%0d", n_checks);

        // Unlock with the correct code, then manual relock on the 5th open cycle.
        guarda = 0;
        while (fase != F_ABERTA && guarda < 100) begin
            ciclo_dir(1'b1, 1'b1, 1'b0, 1'b0);
            guarda++;
        end
        verifica("unlock_reached", {31'd0, fase == F_ABERTA}, 32'd1);
        if (fase == F_ABERTA) begin
            for (int i = 0; i < 4; i++) ciclo_dir(1'b0, 1'b0, 1'b0, 1'b0);
            ciclo_dir(1'b0, 1'b0, 1'b1, 1'b0);
            ciclo_dir(1'b0, 1'b0, 1'b0, 1'b0);
        end
        $display("scenario unlock_fechar done checks=%0d", n_checks);

        // Wrong digits until lockout with timer value 7 remaining, then reset.
        guarda = 0;
        while (!(fase == F_TRAVA && restam == 8) && guarda < 300) begin
            ciclo_dir(1'b1, 1'b0, 1'b0, 1'b0);
            guarda++;
        end
        verifica("lockout_reached", {31'd0, fase == F_TRAVA}, 32'd1);
        aplica_reset();
        for (int i = 0; i < 3; i++) ciclo_dir(1'b0, 1'b0, 1'b0, 1'b0);
        $display("scenario reset_in_lockout done checks=%0d", n_checks);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) aplica_reset();
            ciclo_aleatorio(1'b0);
        end
        $display("scenario random_lock done checks=%0d", n_checks);

        for (int i = 0; i < 2000; i++) ciclo_aleatorio(1'b1);
        $display("scenario random_free_eu done checks=%0d", n_checks);

        aplica_reset();
        for (int i = 0; i < 5; i++) ciclo_aleatorio(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
        $finish;
    end

endmodule
